nx_ram_1rw_pipe: RTL and testbench

- Parametrised single-port (1RW) RAM model for non-specialised depth/width combinations.
- Adds the following to the basic 1RW model:
  - configurable read latency;
  - lane-granular write masking;
  - a hardware init/zeroise state machine;
  - a read-valid strobe.
- Instantiated by engine-local buffers (history, tables, staging) that need deterministic contents after reset without a software clear pass.

---
 rtl/nx_ram_pkg.sv | 29 ++
 rtl/nx_ram_1rw_pipe_if.sv | 35 +++
 rtl/nx_ram_rd_pipe.sv | 38 +++
 rtl/nx_ram_1rw_pipe.sv | 164 ++++++++++++++++
 tb/tb_nx_ram_1rw_pipe.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/nx_ram_pkg.sv
// Shared types and helpers for the nx_ram 1RW pipelined RAM family:
// FSM state encoding, lane arithmetic, lane parity and backdoor opcodes.
package nx_ram_pkg;

  typedef enum logic [1:0] {IDLE, INIT, READY} state_e;

  // Widest word lane_parity can handle; callers zero-extend into it.
  localparam int PAR_MAX_W = 1024;
  localparam int PAR_AW    = 10;

  localparam int BD_GET = 4;
  localparam int BD_SET = 6;

  function automatic int lane_count(input int width, input int gran);
    return width / gran;
  endfunction

  // Even parity per GRAN-bit lane; bit i of the result covers lane i.
  function automatic logic [PAR_MAX_W-1:0] lane_parity(input logic [PAR_MAX_W-1:0] word,
                                                       input int gran);
    logic [PAR_MAX_W-1:0] par;
    par = '0;
    for (int i = 0; i < PAR_MAX_W; i++) begin
      par[PAR_AW'(i / gran)] ^= word[PAR_AW'(i)];
    end
    return par;
  endfunction

endpackage

// File: rtl/nx_ram_1rw_pipe_if.sv
// Access bus of nx_ram_1rw_pipe: init control, request strobe/address/data
// and the pipelined read response.
interface nx_ram_1rw_pipe_if #(
  parameter int WIDTH = 64,
  parameter int GRAN  = 8,
  parameter int DEPTH = 256
);
  import nx_ram_pkg::*;

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LANES = lane_count(WIDTH, GRAN);

  logic             init_start;
  logic             init_done;
  logic             cs;
  logic             we;
  logic [AW-1:0]    add;
  logic [LANES-1:0] bwe;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             access_err;
  logic             par_err;

  modport master (
    output init_start, cs, we, add, bwe, din,
    input  init_done, dout, dout_vld, access_err, par_err
  );

  modport slave (
    input  init_start, cs, we, add, bwe, din,
    output init_done, dout, dout_vld, access_err, par_err
  );

endinterface

// File: rtl/nx_ram_rd_pipe.sv
// RD_LAT-deep data+valid shift register for the RAM read path; flush kills
// every in-flight valid. Data stages only load with a valid, so the output
// word holds between accesses.
module nx_ram_rd_pipe #(
  parameter int WIDTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic [RD_LAT-1:0] vld_q;
  logic [WIDTH-1:0]  data_q [RD_LAT];

  // NOTE: sequential state uses <= so every stage samples its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) data_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld && !flush;
      if (in_vld && !flush) data_q[0] <= in_data;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1] && !flush;
        if (vld_q[i-1] && !flush) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[RD_LAT-1];
  assign out_data = data_q[RD_LAT-1];

endmodule

// File: rtl/nx_ram_1rw_pipe.sv
// Single-port RAM with lane write mask, RD_LAT read pipeline, hardware
// init/zeroise FSM and read-valid strobe. NX_RAM_1RW_PARITY_EN adds per-lane parity.
module nx_ram_1rw_pipe
  import nx_ram_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter int               GRAN      = 8,
  parameter int               DEPTH     = 256,
  parameter int               RD_LAT    = 1,
  parameter bit               AUTO_INIT = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
  input logic              clk,
  input logic              rst_n,
  nx_ram_1rw_pipe_if.slave bus
);

  localparam int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               LANES    = lane_count(WIDTH, GRAN);
  localparam logic [AW:0]      DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    LAST_PTR = AW'(DEPTH - 1);

  if (WIDTH % GRAN != 0) begin : g_bad_gran
    $error("nx_ram_1rw_pipe: WIDTH must be a multiple of GRAN");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("nx_ram_1rw_pipe: RD_LAT must be 1..4");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("nx_ram_1rw_pipe: DEPTH must be at least 2");
  end

  state_e           state_q, state_d;
  logic [AW-1:0]    init_ptr_q, init_ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] bit_mask, rd_word, wr_word;
  logic             addr_ok, acc_ok, flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= AUTO_INIT ? INIT : IDLE;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    init_ptr_d    = init_ptr_q;
    bus.init_done = 1'b0;
    unique case (state_q)
      IDLE: if (bus.init_start) begin
        state_d    = INIT;
        init_ptr_d = '0;
      end
      INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == LAST_PTR) begin
          state_d    = READY;
          init_ptr_d = '0;
        end
      end
      READY: begin
        bus.init_done = 1'b1;
        if (bus.init_start) begin
          state_d    = INIT;
          init_ptr_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < LANES; i++) bit_mask[i*GRAN +: GRAN] = {GRAN{bus.bwe[i]}};
  end

  // Only non-power-of-two depths can present an address past the array end.
  assign addr_ok = {1'b0, bus.add} < DEPTH_W;
  assign acc_ok  = bus.cs && (state_q == READY) && addr_ok;
  assign rd_word = addr_ok ? mem[bus.add] : '0;
  assign wr_word = (rd_word & ~bit_mask) | (bus.din & bit_mask);
  assign flush   = (state_q == READY) && bus.init_start;

  // NOTE: the array is deliberately not reset; contents are defined only by the init sequence.
  always_ff @(posedge clk) begin
    if (state_q == INIT)        mem[init_ptr_q] <= INIT_VAL;
    else if (acc_ok && bus.we)  mem[bus.add]    <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.access_err <= 1'b0;
    else        bus.access_err <= bus.cs && !acc_ok;
  end

`ifdef NX_RAM_1RW_PARITY_EN
  localparam int PW = WIDTH + 1;

  logic [LANES-1:0]     par_mem [DEPTH];
  logic [PAR_MAX_W-1:0] init_par, wr_par, rd_par;
  logic                 rd_perr;

  assign init_par = lane_parity(PAR_MAX_W'(INIT_VAL), GRAN);
  assign wr_par   = lane_parity(PAR_MAX_W'(wr_word), GRAN);
  assign rd_par   = lane_parity(PAR_MAX_W'(rd_word), GRAN);
  assign rd_perr  = !bus.we && addr_ok && (|(rd_par[LANES-1:0] ^ par_mem[bus.add]));

  always_ff @(posedge clk) begin
    if (state_q == INIT)        par_mem[init_ptr_q] <= init_par[LANES-1:0];
    else if (acc_ok && bus.we)  par_mem[bus.add]    <= wr_par[LANES-1:0];
  end

  logic [PW-1:0] pipe_in, pipe_out;
  assign pipe_in     = {rd_perr, bus.we ? wr_word : rd_word};
  assign bus.par_err = bus.dout_vld && pipe_out[WIDTH];
`else
  localparam int PW = WIDTH;

  logic [PW-1:0] pipe_in, pipe_out;
  assign pipe_in     = bus.we ? wr_word : rd_word;
  assign bus.par_err = 1'b0;
`endif

  nx_ram_rd_pipe #(
    .WIDTH  (PW),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_vld   (acc_ok),
    .in_data  (pipe_in),
    .out_vld  (bus.dout_vld),
    .out_data (pipe_out)
  );

  assign bus.dout = pipe_out[WIDTH-1:0];

`ifndef SYNTHESIS
  task get_backdoor(input logic [AW-1:0] a, output logic [WIDTH-1:0] d);
    d = mem[a];
  endtask

  // Writes data only; with parity enabled this is the corruption-injection path.
  task set_backdoor(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    mem[a] <= d;
  endtask

  task backdoor(input int op, input logic [AW-1:0] a, input logic [WIDTH-1:0] wd,
                output logic [WIDTH-1:0] rd);
    rd = '0;
    case (op)
      BD_GET:  get_backdoor(a, rd);
      BD_SET:  set_backdoor(a, wd);
      default: $error("nx_ram_1rw_pipe: unknown backdoor opcode %0d", op);
    endcase
  endtask
`endif

endmodule

// File: tb/tb_nx_ram_1rw_pipe.sv
// Scoreboard bench for nx_ram_1rw_pipe (DEPTH=12, RD_LAT=3): expected reads
// and access errors are queued with their due cycle and matched on the falling edge.
module tb_nx_ram_1rw_pipe;

  localparam int               WIDTH    = 64;
  localparam int               GRAN     = 8;
  localparam int               DEPTH    = 12;
  localparam int               RD_LAT   = 3;
  localparam int               LANES    = WIDTH / GRAN;
  localparam int               AW       = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] INIT_VAL = {8{8'hA5}};

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             perr;
    int               due;
  } rd_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   n;
  bit   ready_model;

  rd_exp_t          rd_q[$];
  int               err_q[$];
  rd_exp_t          mon_e;
  int               mon_due;
  logic [WIDTH-1:0] model [DEPTH];

  nx_ram_1rw_pipe_if #(.WIDTH(WIDTH), .GRAN(GRAN), .DEPTH(DEPTH)) bus ();

  nx_ram_1rw_pipe #(
    .WIDTH     (WIDTH),
    .GRAN      (GRAN),
    .DEPTH     (DEPTH),
    .RD_LAT    (RD_LAT),
    .AUTO_INIT (1'b1),
    .INIT_VAL  (INIT_VAL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one access for a cycle and queue what it must produce.
  task automatic op(input logic w, input logic [AW-1:0] a, input logic [LANES-1:0] be,
                    input logic [WIDTH-1:0] d, input logic pe = 1'b0);
    logic [WIDTH-1:0] merged;
    rd_exp_t          e;
    bus.cs = 1'b1; bus.we = w; bus.add = a; bus.bwe = be; bus.din = d;
    if (!ready_model || int'(a) >= DEPTH) begin
      err_q.push_back(cyc + 1);
    end else begin
      merged = model[a];
      if (w) for (int i = 0; i < LANES; i++) if (be[i]) merged[i*GRAN +: GRAN] = d[i*GRAN +: GRAN];
      model[a] = merged;
      e.data = merged; e.perr = pe; e.due = cyc + RD_LAT;
      rd_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic wait_init(input int start, output int edges);
    edges = start;
    while (!bus.init_done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dout_vld) begin
        check("vld_expected", 64'(rd_q.size() != 0), 64'(1));
        if (rd_q.size() != 0) begin
          mon_e = rd_q.pop_front();
          check("rd_latency", 64'(cyc), 64'(mon_e.due));
          check("dout", bus.dout, mon_e.data);
          check("par_err", 64'(bus.par_err), 64'(mon_e.perr));
        end
      end
      if (bus.access_err) begin
        check("err_expected", 64'(err_q.size() != 0), 64'(1));
        if (err_q.size() != 0) begin
          mon_due = err_q.pop_front();
          check("err_latency", 64'(cyc), 64'(mon_due));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: cycle=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.init_start = 1'b0; bus.cs = 1'b0; bus.we = 1'b0;
    bus.add = '0; bus.bwe = '0; bus.din = '0;
    ready_model = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_init_done",  64'(bus.init_done),  64'(0));
    check("rst_dout",       bus.dout,            64'(0));
    check("rst_dout_vld",   64'(bus.dout_vld),   64'(0));
    check("rst_access_err", 64'(bus.access_err), 64'(0));
    check("rst_par_err",    64'(bus.par_err),    64'(0));
    rst_n = 1'b1;

    // Auto-init with a write attempt at INIT cycle 3 (address 0 already initialised).
    repeat (3) begin @(posedge clk); #1; end
    check("init_busy", 64'(bus.init_done), 64'(0));
    op(1'b1, AW'(0), '1, 64'hDEAD_BEEF_0BAD_F00D);
    wait_init(4, n);
    check("init_len", 64'(n), 64'(DEPTH));
    ready_model = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = INIT_VAL;
    for (int i = 0; i < DEPTH; i++) op(1'b0, AW'(i), '0, '0);

    // Write then read on the next cycle.
    op(1'b1, AW'(5), '1, 64'h1122_3344_5566_7788);
    op(1'b0, AW'(5), '0, '0);

    // Lane mask on an all-ones word, then an all-lanes-off write.
    op(1'b1, AW'(7), '1, '1);
    op(1'b1, AW'(7), 8'h0F, '0);
    op(1'b0, AW'(7), '0, '0);
    repeat (RD_LAT - 1) @(posedge clk);
    #1;
    check("mask_dout", bus.dout, 64'hFFFF_FFFF_0000_0000);
    op(1'b1, AW'(7), '0, 64'h0123_4567_89AB_CDEF);
    op(1'b0, AW'(7), '0, '0);

    // Addresses past the end of a non-power-of-two array.
    op(1'b0, AW'(13), '0, '0);
    op(1'b1, AW'(12), '1, 64'h5A5A_5A5A_5A5A_5A5A);

    repeat (40) op(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                   LANES'($urandom), {$urandom, $urandom});

`ifdef NX_RAM_1RW_PARITY_EN
    dut.set_backdoor(AW'(3), model[3] ^ 64'h0000_0000_0000_0100);
    model[3] = model[3] ^ 64'h0000_0000_0000_0100;
    op(1'b0, AW'(3), '0, '0, 1'b1);
    op(1'b1, AW'(3), '1, 64'h0F0F_0F0F_0F0F_0F0F);
    op(1'b0, AW'(3), '0, '0);
`endif

    repeat (RD_LAT + 1) @(posedge clk);
    #1;

    // Back-to-back reads, then re-init one cycle later: the last two reads are flushed.
    op(1'b1, AW'(2), '1, 64'hCAFE_F00D_1234_5678);
    op(1'b0, AW'(1), '0, '0);
    op(1'b0, AW'(2), '0, '0);
    op(1'b0, AW'(3), '0, '0);
    void'(rd_q.pop_back());
    void'(rd_q.pop_back());
    bus.init_start = 1'b1;
    @(posedge clk); #1;
    bus.init_start = 1'b0;
    ready_model = 1'b0;
    check("reinit_drop", 64'(bus.init_done), 64'(0));
    n = 0;
    while (!bus.init_done && n < 100) begin
      bus.init_start = (n == 5);
      @(posedge clk); #1;
      n++;
    end
    bus.init_start = 1'b0;
    check("reinit_len", 64'(n), 64'(DEPTH));
    ready_model = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = INIT_VAL;
    op(1'b0, AW'(2), '0, '0);
    op(1'b1, AW'(4), '1, 64'h5555_AAAA_5555_AAAA);
    op(1'b0, AW'(4), '0, '0);

    // Asynchronous reset with reads in flight.
    #2 rst_n = 1'b0;
    rd_q.delete();
    err_q.delete();
    #1;
    check("mid_rst_dout",      bus.dout,           64'(0));
    check("mid_rst_dout_vld",  64'(bus.dout_vld),  64'(0));
    check("mid_rst_init_done", 64'(bus.init_done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ready_model = 1'b0;
    @(posedge clk); #1;
    wait_init(1, n);
    check("rst_init_len", 64'(n), 64'(DEPTH));
    ready_model = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = INIT_VAL;
    op(1'b0, AW'(4), '0, '0);

    repeat (RD_LAT + 2) @(posedge clk);
    #1;
    check("rd_q_drained",  64'(rd_q.size()),  64'(0));
    check("err_q_drained", 64'(err_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
